// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_DIV_115200 = 868;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a source and the UART transmitter
interface uart_tx_if;
  import uart_pkg::*;
  logic tx_valid;
  logic [UART_DATA_W-1:0] tx_data;
  logic tx_ready;
  logic tx_busy;
  modport master (output tx_valid, tx_data, input tx_ready, tx_busy);
  modport slave (input tx_valid, tx_data, output tx_ready, tx_busy);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period clock enable, held at phase 0 while clear is high
module uart_baud_gen #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(CLK_DIV - 1);
    cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + 8 data bits LSB first + optional parity + 1/2 stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_DIV_115200,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  uart_tx_if.slave bus,
  output logic tx
);
  tx_state_t state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic stop_q, stop_d, par_q, par_d, tx_q, tx_d, tick, accept;
  initial if (PARITY > 2 || PARITY < 0 || STOP_BITS < 1 || STOP_BITS > 2 || CLK_DIV < 2)
    $error("uart_tx: illegal parameters CLK_DIV=%0d PARITY=%0d STOP_BITS=%0d", CLK_DIV, PARITY, STOP_BITS);
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (.clk(clk), .rst(rst), .clear(state_q == IDLE), .tick(tick));
  assign bus.tx_ready = state_q == IDLE;
  assign bus.tx_busy = state_q != IDLE;
  assign accept = bus.tx_valid && bus.tx_ready;
  assign tx = tx_q;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
    stop_d = stop_q;
    par_d = par_q;
    if (accept) begin
      state_d = START;
      shift_d = bus.tx_data;
      idx_d = '0;
      stop_d = 1'b0;
      par_d = (PARITY == PAR_ODD) ? ~^bus.tx_data : ^bus.tx_data;
    end else if (tick) begin
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          else idx_d = idx_q + 3'd1;
        end
        uart_pkg::PARITY: state_d = STOP;
        STOP: begin
          if (stop_q == 1'(STOP_BITS - 1)) state_d = IDLE;
          else stop_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    // tx is registered from the current state, so the line lags the state by one clock
    tx_d = (state_q == START) ? 1'b0 :
           (state_q == DATA) ? shift_q[0] :
           (state_q == uart_pkg::PARITY) ? par_q : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q <= '0;
      stop_q <= 1'b0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      stop_q <= stop_d;
      par_q <= par_d;
      tx_q <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: several uart_tx configurations driven in parallel against a frame-level line model
module tb_uart_tx;
  localparam int N = 5;
  localparam int DIV_P[N] = '{4, 4, 4, 3, 2};
  localparam int PAR_P[N] = '{0, 1, 2, 0, 2};
  localparam int STP_P[N] = '{1, 1, 1, 2, 2};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic [7:0] data = '0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask
  for (genvar g = 0; g < N; g++) begin : lane
    localparam int D = DIV_P[g];
    localparam int P = PAR_P[g];
    localparam int S = STP_P[g];
    localparam int LEN = (10 + (P != 0 ? 1 : 0) + S - 1) * D;
    uart_tx_if bus ();
    logic txl;
    logic act = 1'b0;
    logic [11:0] bits = '1;
    int j = 0;
    int t;
    logic mrdy;
    assign mrdy = !act || j >= LEN;
    assign bus.tx_valid = valid;
    assign bus.tx_data = data;
    uart_tx #(.CLK_DIV(D), .PARITY(P), .STOP_BITS(S)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .tx(txl));
    function automatic logic [11:0] frame(input logic [7:0] d);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = d;
      if (P != 0) f[9] = (^d) ^ (P == 2);
      return f;
    endfunction
    always @(posedge clk or posedge rst)
      if (rst) begin
        act <= 1'b0;
        j <= 0;
      end else if (valid && mrdy) begin
        act <= 1'b1;
        j <= 0;
        bits <= frame(data);
      end else if (act && j < LEN) j <= j + 1;
    always @(negedge clk) begin
      t = j - 1;
      check($sformatf("tx%0d", g), txl, (act && t >= 0 && t < LEN) ? bits[t / D] : 1'b1);
      check($sformatf("ready%0d", g), bus.tx_ready, mrdy);
      check($sformatf("busy%0d", g), bus.tx_busy, !mrdy);
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic [7:0] after);
    data = d;
    valid = 1'b1;
    cycles(1);
    valid = 1'b0;
    data = after;
  endtask
  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(2);
    send(8'hA5, 8'h5A);
    cycles(60);
    send(8'h07, 8'h00);
    cycles(60);
    data = 8'h00;
    valid = 1'b1;
    cycles(1);
    data = 8'hFF;
    cycles(120);
    valid = 1'b0;
    cycles(60);
    send(8'h3C, 8'hC3);
    cycles(60);
    send(8'h11, 8'h22);
    cycles(10);
    send(8'h99, 8'h00);
    cycles(60);
    send(8'h00, 8'h00);
    cycles(18);
    #1 rst = 1'b1;
    cycles(3);
    #1 rst = 1'b0;
    cycles(10);
    send(8'h6B, 8'h00);
    cycles(60);
    repeat (300) begin
      valid = 1'b1;
      data = 8'($urandom);
      cycles(1);
    end
    repeat (3000) begin
      valid = $urandom_range(0, 3) == 0;
      data = 8'($urandom);
      cycles(1);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        cycles(2);
        #1 rst = 1'b0;
      end
    end
    valid = 1'b0;
    cycles(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
